// File: rtl/reset_release_sequencer.sv
`timescale 1ns/1ps
// reset_release_sequencer
// Brings the global asynchronous reset and the PLL lock indication into the
// core clock domain. Once lock has been stable for a hold period, it releases
// NUM_DOMAINS active-high domain resets one at a time, bit 0 first. Losing lock
// after the hold period has started puts every domain back into reset together
// and restarts the wait for lock.
// Build option: define RST_SEQ_LOCK_FILTER_EN to debounce the lock indication.
// With it, lock only counts after LOCK_FILTER_CYCLES consecutive high cycles.
module reset_release_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int HOLD_CYCLES        = 256,
  parameter int NUM_DOMAINS        = 3,
  parameter int STAGGER_CYCLES     = 16,
  parameter int LOCK_FILTER_CYCLES = 8
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_locked,
  output logic [NUM_DOMAINS-1:0] o_rst_seq,
  output logic                   o_ready,
  output logic                   o_LED,
  output logic [7:0]             o_lock_loss_cnt,
  output logic [2:0]             o_state
);

  localparam int MaxCycles = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] HoldLast    = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StaggerLast = CntW'(STAGGER_CYCLES - 1);

  typedef enum logic [2:0] {
    StReset    = 3'd0,
    StWaitLock = 3'd1,
    StHold     = 3'd2,
    StRelease  = 3'd3,
    StRun      = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] rstChain_q;
  logic [SYNC_STAGES-1:0] lockChain_q;
  logic                   rstSync;
  logic                   lockedSync;
  logic                   lockOk;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      idxNext;
  logic [NUM_DOMAINS-1:0] rstSeq_q, rstSeq_d;
  logic            ready_q, ready_d;
  logic            led_q;
  logic [7:0]      lossCnt_q, lossCnt_d;
  logic            lossEvent;

  // Reset bridge: asserts immediately with i_rst, releases only after the zero
  // has walked through every stage on i_clk.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rstChain_q <= '1;
    else       rstChain_q <= {rstChain_q[SYNC_STAGES-2:0], 1'b0};
  end

  // Lock synchroniser: i_locked comes from the PLL with no relation to i_clk.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) lockChain_q <= '0;
    else       lockChain_q <= {lockChain_q[SYNC_STAGES-2:0], i_locked};
  end

  assign rstSync    = rstChain_q[SYNC_STAGES-1];
  assign lockedSync = lockChain_q[SYNC_STAGES-1];

`ifdef RST_SEQ_LOCK_FILTER_EN
  localparam int FiltW = $clog2(LOCK_FILTER_CYCLES + 1);
  localparam logic [FiltW-1:0] FiltFull = FiltW'(LOCK_FILTER_CYCLES);
  logic [FiltW-1:0] filtCnt_q;

  // Debounce: count consecutive synchronised-high cycles and hold at full.
  // Any low cycle restarts the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  filtCnt_q <= '0;
    else if (!lockedSync)       filtCnt_q <= '0;
    else if (filtCnt_q != FiltFull) filtCnt_q <= filtCnt_q + FiltW'(1);
  end

  assign lockOk = lockedSync && (filtCnt_q == FiltFull);
`else
  assign lockOk = lockedSync;
`endif

  // Sequencer state and all registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= StReset;
      cnt_q     <= '0;
      idx_q     <= '0;
      rstSeq_q  <= '1;
      ready_q   <= 1'b0;
      lossCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rstSeq_q  <= rstSeq_d;
      ready_q   <= ready_d;
      lossCnt_q <= lossCnt_d;
    end
  end

  // The LED trails o_ready by one edge so it only lights once everything is up.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) led_q <= 1'b0;
    else       led_q <= ready_q;
  end

  // Next state: wait for lock, hold, release the domains one by one, then run.
  // Losing lock anywhere after the hold has started forces every domain back
  // into reset at once. Released bits are never set again individually.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rstSeq_d  = rstSeq_q;
    ready_d   = ready_q;
    lossCnt_d = lossCnt_q;
    lossEvent = 1'b0;
    idxNext   = idx_q + 3'd1;

    unique case (state_q)
      StReset: begin
        if (!rstSync) state_d = StWaitLock;
      end
      StWaitLock: begin
        if (lockOk) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (!lockOk) begin
          lossEvent = 1'b1;
        end else if (cnt_q == HoldLast) begin
          cnt_d       = '0;
          idx_d       = '0;
          rstSeq_d[0] = 1'b0;
          if (NUM_DOMAINS == 1) begin
            state_d = StRun;
            ready_d = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease: begin
        if (!lockOk) begin
          lossEvent = 1'b1;
        end else if (cnt_q == StaggerLast) begin
          cnt_d = '0;
          idx_d = idxNext;
          for (int k = 0; k < NUM_DOMAINS; k++) begin
            if (k == int'(idxNext)) rstSeq_d[k] = 1'b0;
          end
          if (int'(idxNext) == NUM_DOMAINS - 1) begin
            state_d = StRun;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRun: begin
        if (!lockOk) lossEvent = 1'b1;
      end
      default: begin
        state_d = StReset;
      end
    endcase

    if (lossEvent) begin
      state_d  = StWaitLock;
      cnt_d    = '0;
      rstSeq_d = '1;
      ready_d  = 1'b0;
      if (lossCnt_q != 8'hFF) lossCnt_d = lossCnt_q + 8'd1;
    end
  end

  assign o_rst_seq       = rstSeq_q;
  assign o_ready         = ready_q;
  assign o_LED           = led_q;
  assign o_lock_loss_cnt = lossCnt_q;
  assign o_state         = state_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
`timescale 1ns/1ps
// Bench for reset_release_sequencer with its default parameters.
// The reference model works on a timeline. It records the edge where the
// sequence started, and each output comes from the time elapsed since that
// edge. Each scenario task compares the DUT against the model on every cycle
// and against fixed edge numbers derived from the timing rules.
module tb_reset_release_sequencer;

  localparam int SYNC    = 2;
  localparam int HOLD    = 256;
  localparam int NDOM    = 3;
  localparam int STAG    = 16;
  localparam int LastRel = HOLD + (NDOM - 1) * STAG;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_locked = 1'b1;
  logic [NDOM-1:0] o_rst_seq;
  logic            o_ready;
  logic            o_LED;
  logic [7:0]      o_lock_loss_cnt;
  logic [2:0]      o_state;

  int vectors = 0;
  int miscompares = 0;

  reset_release_sequencer #(
    .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .NUM_DOMAINS(NDOM),
    .STAGGER_CYCLES(STAG), .LOCK_FILTER_CYCLES(8)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_locked(i_locked),
    .o_rst_seq(o_rst_seq), .o_ready(o_ready), .o_LED(o_LED),
    .o_lock_loss_cnt(o_lock_loss_cnt), .o_state(o_state)
  );

  // 5.5 ns core clock
  always #2.75 i_clk = ~i_clk;

  // Reference model state
  int              mEdge, mStart, mLoss, t;
  bit              mActive, lockSeen;
  bit              mSync [SYNC];
  logic [NDOM-1:0] mRstSeq;
  logic            mReady, mLed;
  logic [2:0]      mState;

  // The model counts edges since reset release. The FSM first evaluates lock
  // on edge SYNC+2. From the edge where the sequence starts, the hold and
  // stagger arithmetic gives every output directly.
  always @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mEdge = 0; mStart = 0; mLoss = 0; mActive = 0;
      foreach (mSync[k]) mSync[k] = 1'b0;
      mRstSeq = '1; mReady = 1'b0; mLed = 1'b0; mState = 3'd0;
    end else begin
      mEdge++;
      lockSeen = mSync[SYNC-1];
      if (mEdge >= SYNC + 2) begin
        if (!mActive && lockSeen) begin
          mActive = 1'b1;
          mStart  = mEdge;
        end else if (mActive && !lockSeen) begin
          mActive = 1'b0;
          if (mLoss < 255) mLoss++;
        end
      end
      for (int k = SYNC - 1; k > 0; k--) mSync[k] = mSync[k-1];
      mSync[0] = i_locked;
      mLed = mReady;
      if (mActive) begin
        t = mEdge - mStart;
        for (int k = 0; k < NDOM; k++) mRstSeq[k] = (t < HOLD + k * STAG);
        mReady = (t >= LastRel);
        mState = (t < HOLD) ? 3'd2 : (mReady ? 3'd4 : 3'd3);
      end else begin
        mRstSeq = '1;
        mReady  = 1'b0;
        mState  = (mEdge >= SYNC + 1) ? 3'd1 : 3'd0;
      end
    end
  end

  task automatic applyStimulus(input bit lockVal);
    i_rst = 1'b1;
    i_locked = lockVal;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_locked = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      vectors++;
      if ({o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state} !== {3'b111, 1'b0, 1'b0, 8'd0, 3'd0}) begin
        miscompares++;
        $display("[TB] FAIL reset_values got rst=%b rdy=%b led=%b loss=%0d st=%0d exp rst=111 rdy=0 led=0 loss=0 st=0",
                 o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state);
      end
    end
  endtask

  // Power-up with lock steady high. Releases land on edges 260, 276 and 292,
  // and the LED lights on edge 293.
  task automatic test_power_up(input string tag);
    logic [4:0] expFix;
    applyStimulus(1'b1);
    for (int c = 1; c <= 300; c++) begin
      @(negedge i_clk);
      vectors++;
      if ({o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state} !== {mRstSeq, mReady, mLed, 8'(mLoss), mState}) begin
        miscompares++;
        $display("[TB] FAIL %s_model edge=%0d got rst=%b rdy=%b led=%b loss=%0d st=%0d exp rst=%b rdy=%b led=%b loss=%0d st=%0d",
                 tag, c, o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state, mRstSeq, mReady, mLed, mLoss, mState);
      end
      if (c inside {3, 4, 259, 260, 275, 276, 291, 292, 293}) begin
        case (c)
          259, 3, 4: expFix = 5'b111_0_0;
          260, 275:  expFix = 5'b110_0_0;
          276, 291:  expFix = 5'b100_0_0;
          292:       expFix = 5'b000_1_0;
          default:   expFix = 5'b000_1_1;
        endcase
        vectors++;
        if ({o_rst_seq, o_ready, o_LED} !== expFix) begin
          miscompares++;
          $display("[TB] FAIL %s_edge%0d got {rst,rdy,led}=%b exp %b", tag, c, {o_rst_seq, o_ready, o_LED}, expFix);
        end
      end
    end
  endtask

  // Lock arrives about 1 us after reset release.
  task automatic test_lock_late();
    int lowLen;
    lowLen = $urandom_range(170, 200);
    applyStimulus(1'b0);
    for (int c = 1; c <= lowLen + 300; c++) begin
      @(negedge i_clk);
      vectors++;
      if ({o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state} !== {mRstSeq, mReady, mLed, 8'(mLoss), mState}) begin
        miscompares++;
        $display("[TB] FAIL late_model edge=%0d got rst=%b rdy=%b led=%b loss=%0d st=%0d exp rst=%b rdy=%b led=%b loss=%0d st=%0d",
                 c, o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state, mRstSeq, mReady, mLed, mLoss, mState);
      end
      if (c == lowLen || c == lowLen + 300) begin
        vectors++;
        if ((c == lowLen && {o_rst_seq, o_lock_loss_cnt, o_state} !== {3'b111, 8'd0, 3'd1}) ||
            (c != lowLen && {o_rst_seq, o_LED, o_lock_loss_cnt, o_state} !== {3'b000, 1'b1, 8'd0, 3'd4})) begin
          miscompares++;
          $display("[TB] FAIL late_edge%0d got rst=%b led=%b loss=%0d st=%0d", c, o_rst_seq, o_LED, o_lock_loss_cnt, o_state);
        end
      end
      if (c == lowLen) i_locked = 1'b1;
    end
  endtask

  // A one-cycle lock glitch during HOLD restarts the hold from zero.
  task automatic test_hold_glitch();
    int dropEdge;
    dropEdge = 4 + $urandom_range(20, 200);
    applyStimulus(1'b1);
    for (int c = 1; c <= dropEdge + 300; c++) begin
      @(negedge i_clk);
      vectors++;
      if ({o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state} !== {mRstSeq, mReady, mLed, 8'(mLoss), mState}) begin
        miscompares++;
        $display("[TB] FAIL glitch_model edge=%0d got rst=%b rdy=%b led=%b loss=%0d st=%0d exp rst=%b rdy=%b led=%b loss=%0d st=%0d",
                 c, o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state, mRstSeq, mReady, mLed, mLoss, mState);
      end
      if (c == dropEdge + 3) begin
        vectors++;
        if ({o_rst_seq, o_lock_loss_cnt, o_state} !== {3'b111, 8'd1, 3'd1}) begin
          miscompares++;
          $display("[TB] FAIL glitch_wait got rst=%b loss=%0d st=%0d exp rst=111 loss=1 st=1", o_rst_seq, o_lock_loss_cnt, o_state);
        end
      end
      if (c == dropEdge + 291 || c == dropEdge + 292) begin
        vectors++;
        if (o_rst_seq !== ((c == dropEdge + 291) ? 3'b100 : 3'b000) || o_lock_loss_cnt !== 8'd1) begin
          miscompares++;
          $display("[TB] FAIL glitch_rerelease edge=%0d got rst=%b loss=%0d", c, o_rst_seq, o_lock_loss_cnt);
        end
      end
      if (c == dropEdge)     i_locked = 1'b0;
      if (c == dropEdge + 1) i_locked = 1'b1;
    end
  endtask

  // Lock lost for several cycles while running.
  task automatic test_run_loss();
    int dur;
    dur = $urandom_range(5, 15);
    applyStimulus(1'b1);
    for (int c = 1; c <= 300 + dur + 300; c++) begin
      @(negedge i_clk);
      vectors++;
      if ({o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state} !== {mRstSeq, mReady, mLed, 8'(mLoss), mState}) begin
        miscompares++;
        $display("[TB] FAIL runloss_model edge=%0d got rst=%b rdy=%b led=%b loss=%0d st=%0d exp rst=%b rdy=%b led=%b loss=%0d st=%0d",
                 c, o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state, mRstSeq, mReady, mLed, mLoss, mState);
      end
      if (c inside {302, 303, 304}) begin
        vectors++;
        if ({o_rst_seq, o_ready, o_LED} !== ((c == 302) ? 5'b000_1_1 : (c == 303) ? 5'b111_0_1 : 5'b111_0_0)) begin
          miscompares++;
          $display("[TB] FAIL runloss_edge%0d got {rst,rdy,led}=%b", c, {o_rst_seq, o_ready, o_LED});
        end
      end
      if (c == 600 + dur) begin
        vectors++;
        if ({o_rst_seq, o_LED, o_lock_loss_cnt} !== {3'b000, 1'b1, 8'd1}) begin
          miscompares++;
          $display("[TB] FAIL runloss_recover got rst=%b led=%b loss=%0d exp rst=000 led=1 loss=1", o_rst_seq, o_LED, o_lock_loss_cnt);
        end
      end
      if (c == 300)       i_locked = 1'b0;
      if (c == 300 + dur) i_locked = 1'b1;
    end
  endtask

  // Global reset reasserted while bit 0 is released but bit 1 is not.
  task automatic test_async_reset();
    int stopEdge;
    stopEdge = $urandom_range(261, 274);
    applyStimulus(1'b1);
    for (int c = 1; c <= stopEdge; c++) begin
      @(negedge i_clk);
      vectors++;
      if ({o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state} !== {mRstSeq, mReady, mLed, 8'(mLoss), mState}) begin
        miscompares++;
        $display("[TB] FAIL async_model edge=%0d got rst=%b rdy=%b led=%b loss=%0d st=%0d exp rst=%b rdy=%b led=%b loss=%0d st=%0d",
                 c, o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state, mRstSeq, mReady, mLed, mLoss, mState);
      end
    end
    vectors++;
    if (o_rst_seq !== 3'b110) begin
      miscompares++;
      $display("[TB] FAIL async_pre got rst=%b exp 110", o_rst_seq);
    end
    #0.5 i_rst = 1'b1;
    #0.1;
    vectors++;
    if ({o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state} !== {3'b111, 1'b0, 1'b0, 8'd0, 3'd0}) begin
      miscompares++;
      $display("[TB] FAIL async_assert got rst=%b rdy=%b led=%b loss=%0d st=%0d exp rst=111 rdy=0 led=0 loss=0 st=0",
               o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state);
    end
    test_power_up("restart");
  endtask

  // Repeated short lock pulses push the loss counter into saturation.
  task automatic test_saturation();
    applyStimulus(1'b1);
    for (int c = 1; c <= 4 + 270 * 6; c++) begin
      @(negedge i_clk);
      vectors++;
      if ({o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state} !== {mRstSeq, mReady, mLed, 8'(mLoss), mState}) begin
        miscompares++;
        $display("[TB] FAIL sat_model edge=%0d got rst=%b rdy=%b led=%b loss=%0d st=%0d exp rst=%b rdy=%b led=%b loss=%0d st=%0d",
                 c, o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state, mRstSeq, mReady, mLed, mLoss, mState);
      end
      if (c >= 4) i_locked = (((c - 4) / 3) % 2) != 0;
    end
    repeat (4) @(negedge i_clk);
    vectors++;
    if (o_lock_loss_cnt !== 8'd255) begin
      miscompares++;
      $display("[TB] FAIL sat_count got loss=%0d exp 255", o_lock_loss_cnt);
    end
  endtask

  // Random lock levels of random length, checked against the model.
  task automatic test_random();
    int segLen;
    applyStimulus(1'($urandom_range(0, 1)));
    for (int s = 0; s < 8; s++) begin
      segLen = $urandom_range(1, 350);
      for (int c = 0; c < segLen; c++) begin
        @(negedge i_clk);
        vectors++;
        if ({o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state} !== {mRstSeq, mReady, mLed, 8'(mLoss), mState}) begin
          miscompares++;
          $display("[TB] FAIL random_model edge=%0d got rst=%b rdy=%b led=%b loss=%0d st=%0d exp rst=%b rdy=%b led=%b loss=%0d st=%0d",
                   mEdge, o_rst_seq, o_ready, o_LED, o_lock_loss_cnt, o_state, mRstSeq, mReady, mLed, mLoss, mState);
        end
      end
      i_locked = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_power_up("powerup");
    test_lock_late();
    test_hold_glitch();
    test_run_loss();
    test_async_reset();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
